mem_line_sched: RTL and testbench

- Schedules 64-byte line reads from two requesters onto the shared Sysbus request/response channel.
- Requester I is instruction fetch; requester D is data load.
- Arbitrates round-robin with one transaction outstanding.
- Assembles the 8 response beats into a line and returns it to the granted requester with a one-cycle completion pulse.

---
 rtl/mem_line_sched.sv | 148 ++++++++++++++
 tb/tb_mem_line_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_sched.sv
// Round-robin line-read scheduler: two requesters (I fetch, D load) share one
// Sysbus request/response channel, one 8-beat line transaction at a time.
module mem_line_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BYTES = 64,
  parameter int TAG_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic [63:0]               i_addr,
  output logic                      i_ack,
  output logic                      i_done,
  output logic [LINE_BYTES*8-1:0]   i_line,
  input  logic                      d_req,
  input  logic [63:0]               d_addr,
  output logic                      d_ack,
  output logic                      d_done,
  output logic [LINE_BYTES*8-1:0]   d_line,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [TAG_WIDTH-1:0]      bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [DATA_WIDTH-1:0]     bus_resp,
  input  logic [TAG_WIDTH-1:0]      bus_resptag,
  output logic                      bus_respack,
  output logic                      proto_err
);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BEATS  = LINE_W / DATA_WIDTH;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic                r_last_d;
  logic                r_gnt_d;
  logic                r_reqcyc;
  logic [63:0]         r_bus_req;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                r_i_ack, r_d_ack, r_i_done, r_d_done;
  logic                r_err;
  logic [LINE_W-1:0]   r_buf, r_i_line, r_d_line;

  logic                w_pick_d;
  logic [7:0]          w_gnt_id;
  logic                w_take_state;
  logic                w_take;
  logic                w_last;
  logic [LINE_W-1:0]   w_line;

  assign w_pick_d     = d_req && (!i_req || !r_last_d);
  assign w_gnt_id     = r_gnt_d ? 8'h02 : 8'h01;
  assign w_take_state = (r_state == S_WAIT) || (r_state == S_RESP) ||
                        (r_state == S_REQ && bus_reqack);
  assign w_take       = w_take_state && bus_respcyc && (bus_resptag[7:0] == w_gnt_id);
  assign w_last       = (r_beat_cnt == CNT_W'(BEATS - 1));

  always_comb begin
    w_line = r_buf;
    w_line[r_beat_cnt*DATA_WIDTH +: DATA_WIDTH] = bus_resp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_last_d   <= 1'b1;
      r_gnt_d    <= 1'b0;
      r_reqcyc   <= 1'b0;
      r_bus_req  <= '0;
      r_tag      <= '0;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_err      <= 1'b0;
      r_buf      <= '0;
      r_i_line   <= '0;
      r_d_line   <= '0;
    end else begin
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;

      if (bus_respcyc && !w_take) r_err <= 1'b1;
      if (bus_reqack && r_state != S_REQ) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_req || d_req) begin
            r_gnt_d   <= w_pick_d;
            r_last_d  <= w_pick_d;
            r_reqcyc  <= 1'b1;
            r_bus_req <= (w_pick_d ? d_addr : i_addr) & ~64'(LINE_BYTES - 1);
            r_tag     <= TAG_WIDTH'({1'b1, 4'b0001, (w_pick_d ? 8'h02 : 8'h01)});
            r_i_ack   <= !w_pick_d;
            r_d_ack   <= w_pick_d;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_reqack) begin
            r_reqcyc <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: ;
      endcase

      // Beat capture sits after the case so it also covers a beat arriving with
      // bus_reqack; its state update overrides the REQ->WAIT move above.
      if (w_take) begin
        r_buf      <= w_line;
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        if (w_last) begin
          r_state <= S_DONE;
          if (r_gnt_d) begin
            r_d_line <= w_line;
            r_d_done <= 1'b1;
          end else begin
            r_i_line <= w_line;
            r_i_done <= 1'b1;
          end
        end else begin
          r_state <= S_RESP;
        end
      end
    end
  end

  assign i_ack       = r_i_ack;
  assign d_ack       = r_d_ack;
  assign i_done      = r_i_done;
  assign d_done      = r_d_done;
  assign i_line      = r_i_line;
  assign d_line      = r_d_line;
  assign bus_reqcyc  = r_reqcyc;
  assign bus_req     = r_bus_req;
  assign bus_reqtag  = r_tag;
  assign bus_respack = bus_respcyc;
  assign proto_err   = r_err;

endmodule

// File: tb/tb_mem_line_sched.sv
// Self-checking bench for mem_line_sched: a bus-slave driver plus a spec-level
// model of grant order, request address/tag, completion latency and line contents.
module tb_mem_line_sched;
  logic         clk = 1'b0;
  logic         reset;
  logic         i_req, d_req;
  logic [63:0]  i_addr, d_addr;
  logic         i_ack, i_done, d_ack, d_done;
  logic [511:0] i_line, d_line;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack, bus_respcyc, bus_respack, proto_err;
  logic [63:0]  bus_resp;
  logic [12:0]  bus_resptag;

  always #5 clk = ~clk;

  mem_line_sched #(.DATA_WIDTH(64), .LINE_BYTES(64), .TAG_WIDTH(13)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_done(i_done), .i_line(i_line),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_done(d_done), .d_line(d_line),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  logic         m_last_d;
  logic [511:0] m_i_line, m_d_line;
  logic [63:0]  sent [8];

  // Observations collected by the bus driver
  int           o_ack_cyc, o_done_cyc, o_reqcyc_n;
  logic         o_i_ack, o_d_ack, o_unstable, o_drop_ok, o_early, o_pulse_ok, o_timeout;
  logic         o_i_done, o_d_done, o_respack_bad;
  logic [63:0]  o_addr;
  logic [12:0]  o_tag;

  function automatic logic pick_d(input logic ir, input logic dr, input logic last_d);
    if (ir && dr) return !last_d;
    return dr;
  endfunction

  function automatic logic [511:0] sent_line();
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = sent[k];
    return l;
  endfunction

  // Acts as the bus target for one transaction and records what it sees.
  task automatic serve(input int ack_dly, input int gap, input bit bad, input logic [7:0] id,
                       input bit drop, input int abort_after, input bit fixed);
    int cyc, poll;
    cyc = 0; o_timeout = 0; o_unstable = 0; o_early = 0; o_reqcyc_n = 0;
    o_drop_ok = 0; o_pulse_ok = 0; o_respack_bad = 0; o_done_cyc = -1;
    o_i_done = 0; o_d_done = 0;
    for (int k = 0; k < 8; k++)
      sent[k] = fixed ? 64'((k + 1) * 17) : {$urandom, $urandom};
    @(negedge clk); cyc = 1;
    while (bus_reqcyc !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    if (bus_reqcyc !== 1'b1) begin o_timeout = 1; return; end
    o_ack_cyc = cyc; o_i_ack = i_ack; o_d_ack = d_ack; o_addr = bus_req; o_tag = bus_reqtag;
    if (drop) begin i_req = 1'b0; d_req = 1'b0; end
    for (int k = 0; k < ack_dly; k++) begin
      if (bus_reqcyc !== 1'b1 || bus_req !== o_addr || bus_reqtag !== o_tag) o_unstable = 1;
      o_reqcyc_n++;
      @(negedge clk); cyc++;
      if (i_ack || d_ack) o_unstable = 1;
    end
    if (bus_reqcyc !== 1'b1 || bus_req !== o_addr || bus_reqtag !== o_tag) o_unstable = 1;
    o_reqcyc_n++;
    bus_reqack = 1'b1;
    @(negedge clk); cyc++;
    bus_reqack = 1'b0;
    o_drop_ok = (bus_reqcyc === 1'b0);
    for (int b = 0; b < 8; b++) begin
      if (abort_after > 0 && b == abort_after) begin bus_respcyc = 1'b0; return; end
      if (bad && b == 3) begin
        bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom};
        bus_resptag = {1'b1, 4'b0001, id ^ 8'h03};
        @(negedge clk); cyc++;
      end
      if (b == 4) begin
        for (int g = 0; g < gap; g++) begin
          bus_respcyc = 1'b0;
          @(negedge clk); cyc++;
          if (i_done || d_done) o_early = 1;
        end
      end
      if (i_done || d_done) o_early = 1;
      bus_respcyc = 1'b1; bus_resp = sent[b]; bus_resptag = {1'b1, 4'b0001, id};
      #1 if (bus_respack !== 1'b1) o_respack_bad = 1;
      @(negedge clk); cyc++;
    end
    bus_respcyc = 1'b0;
    poll = 0;
    while (!(i_done || d_done) && poll < 6) begin @(negedge clk); cyc++; poll++; end
    o_done_cyc = cyc; o_i_done = i_done; o_d_done = d_done;
    @(negedge clk);
    o_pulse_ok = !(i_done || d_done);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 0; d_req = 0; i_addr = '0; d_addr = '0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    m_last_d = 1'b1; m_i_line = '0; m_d_line = '0;
    repeat (3) @(negedge clk);
    checks++; if ({bus_reqcyc, i_ack, d_ack, i_done, d_done, proto_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {bus_reqcyc, i_ack, d_ack, i_done, d_done, proto_err}); end
    checks++; if (bus_req !== 64'h0 || bus_reqtag !== 13'h0) begin
      errors++; $display("FAIL reset_bus got req=%h tag=%h want 0/0", bus_req, bus_reqtag); end
    checks++; if (i_line !== 512'h0 || d_line !== 512'h0) begin
      errors++; $display("FAIL reset_lines got nonzero want 0"); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    i_req = 1'b1; i_addr = 64'h1234; d_req = 1'b0;
    serve(0, 0, 0, 8'h01, 1, 0, 1);
    m_last_d = 1'b0; m_i_line = sent_line();
    checks++; if (o_timeout) begin errors++; $display("FAIL single_timeout got none want reqcyc"); end
    checks++; if (o_ack_cyc != 1 || o_i_ack !== 1'b1 || o_d_ack !== 1'b0) begin
      errors++; $display("FAIL single_ack got cyc=%0d i=%b d=%b want 1/1/0", o_ack_cyc, o_i_ack, o_d_ack); end
    checks++; if (o_addr !== 64'h1200 || o_tag !== 13'h1101) begin
      errors++; $display("FAIL single_req got %h/%h want 1200/1101", o_addr, o_tag); end
    checks++; if (!o_drop_ok) begin errors++; $display("FAIL single_reqcyc_drop got 1 want 0"); end
    checks++; if (o_done_cyc != 10 || o_i_done !== 1'b1 || o_d_done !== 1'b0) begin
      errors++; $display("FAIL single_done got cyc=%0d i=%b d=%b want 10/1/0", o_done_cyc, o_i_done, o_d_done); end
    checks++; if (i_line[63:0] !== 64'h11 || i_line[511:448] !== 64'h88) begin
      errors++; $display("FAIL single_ends got %h/%h want 11/88", i_line[63:0], i_line[511:448]); end
    checks++; if (i_line !== m_i_line || d_line !== m_d_line) begin
      errors++; $display("FAIL single_line got %h want %h", i_line, m_i_line); end
    checks++; if (!o_pulse_ok || o_early || o_respack_bad || proto_err !== 1'b0) begin
      errors++; $display("FAIL single_misc got pulse=%b early=%b respack_bad=%b err=%b want 1/0/0/0",
                          o_pulse_ok, o_early, o_respack_bad, proto_err); end
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    i_req = 1'b1; d_req = 1'b1;
    i_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom};
    for (int t = 0; t < 4; t++) begin
      exp_d = pick_d(1'b1, 1'b1, m_last_d);
      serve(0, 0, 0, exp_d ? 8'h02 : 8'h01, 0, 0, 0);
      m_last_d = exp_d;
      if (exp_d) m_d_line = sent_line(); else m_i_line = sent_line();
      checks++; if (o_timeout || o_ack_cyc != 1 || o_d_ack !== exp_d || o_i_ack !== !exp_d) begin
        errors++; $display("FAIL b2b_grant[%0d] got to=%b cyc=%0d d_ack=%b want cyc=1 d_ack=%b",
                           t, o_timeout, o_ack_cyc, o_d_ack, exp_d); end
      checks++; if (o_tag[7:0] !== (exp_d ? 8'h02 : 8'h01) ||
                    o_addr !== ((exp_d ? d_addr : i_addr) & ~64'h3f)) begin
        errors++; $display("FAIL b2b_req[%0d] got tag=%h addr=%h", t, o_tag, o_addr); end
      checks++; if (o_done_cyc != 10 || o_d_done !== exp_d || i_line !== m_i_line || d_line !== m_d_line) begin
        errors++; $display("FAIL b2b_line[%0d] got done=%0d d_done=%b want 10/%b", t, o_done_cyc, o_d_done, exp_d); end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_delay();
    d_req = 1'b1; d_addr = {$urandom, $urandom};
    serve(5, 0, 0, 8'h02, 1, 0, 0);
    m_last_d = 1'b1; m_d_line = sent_line();
    checks++; if (o_timeout || o_reqcyc_n != 6 || o_unstable) begin
      errors++; $display("FAIL ackdly_hold got n=%0d unstable=%b want 6/0", o_reqcyc_n, o_unstable); end
    checks++; if (!o_drop_ok || o_done_cyc != 15 || d_line !== m_d_line) begin
      errors++; $display("FAIL ackdly_done got drop=%b cyc=%0d want 1/15", o_drop_ok, o_done_cyc); end
  endtask

  task automatic test_gaps();
    i_req = 1'b1; i_addr = {$urandom, $urandom};
    serve(0, 3, 0, 8'h01, 1, 0, 0);
    m_last_d = 1'b0; m_i_line = sent_line();
    checks++; if (o_timeout || o_early || o_done_cyc != 13) begin
      errors++; $display("FAIL gaps_done got early=%b cyc=%0d want 0/13", o_early, o_done_cyc); end
    checks++; if (i_line !== m_i_line || d_line !== m_d_line) begin
      errors++; $display("FAIL gaps_line got %h want %h", i_line, m_i_line); end
  endtask

  task automatic test_random();
    logic ir, dr, exp_d;
    int dly, gap, pat;
    for (int t = 0; t < 12; t++) begin
      pat = $urandom_range(1, 3); ir = pat[0]; dr = pat[1];
      dly = $urandom_range(0, 3); gap = $urandom_range(0, 2);
      i_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom};
      i_req = ir; d_req = dr;
      exp_d = pick_d(ir, dr, m_last_d);
      serve(dly, gap, 0, exp_d ? 8'h02 : 8'h01, 1, 0, 0);
      m_last_d = exp_d;
      if (exp_d) m_d_line = sent_line(); else m_i_line = sent_line();
      checks++; if (o_timeout || o_d_ack !== exp_d || o_i_ack !== !exp_d ||
                    o_addr !== ((exp_d ? d_addr : i_addr) & ~64'h3f) ||
                    o_tag !== {1'b1, 4'b0001, (exp_d ? 8'h02 : 8'h01)}) begin
        errors++; $display("FAIL rand_req[%0d] got d_ack=%b addr=%h tag=%h want d=%b", t, o_d_ack, o_addr, o_tag, exp_d); end
      checks++; if (o_done_cyc != 10 + dly + gap || o_d_done !== exp_d || o_i_done !== !exp_d ||
                    i_line !== m_i_line || d_line !== m_d_line || o_unstable || o_early) begin
        errors++; $display("FAIL rand_done[%0d] got cyc=%0d d_done=%b want %0d/%b", t, o_done_cyc, o_d_done, 10 + dly + gap, exp_d); end
    end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rand_err got 1 want 0"); end
  endtask

  task automatic test_bad_tag();
    i_req = 1'b1; i_addr = {$urandom, $urandom};
    serve(0, 0, 1, 8'h01, 1, 0, 0);
    m_last_d = 1'b0; m_i_line = sent_line();
    checks++; if (o_timeout || o_done_cyc != 11 || i_line !== m_i_line) begin
      errors++; $display("FAIL badtag_line got cyc=%0d want 11", o_done_cyc); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL badtag_err got %b want 1", proto_err); end
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_addr = {$urandom, $urandom};
    serve(0, 0, 0, 8'h01, 1, 4, 0);
    reset = 1'b1;
    #1;
    checks++; if (o_early || {bus_reqcyc, i_ack, d_ack, i_done, d_done, proto_err} !== 6'b0 ||
                  bus_req !== 64'h0 || bus_reqtag !== 13'h0 || i_line !== 512'h0 || d_line !== 512'h0) begin
      errors++; $display("FAIL midreset_outs got flags=%b req=%h early=%b want 0",
                         {bus_reqcyc, i_ack, d_ack, i_done, d_done, proto_err}, bus_req, o_early); end
    @(negedge clk);
    reset = 1'b0;
    m_last_d = 1'b1; m_i_line = '0; m_d_line = '0;
    @(negedge clk);
    i_req = 1'b1; i_addr = {$urandom, $urandom};
    serve(0, 0, 0, 8'h01, 1, 0, 0);
    m_i_line = sent_line();
    checks++; if (o_timeout || o_ack_cyc != 1 || o_done_cyc != 10 || o_i_done !== 1'b1) begin
      errors++; $display("FAIL midreset_fresh got ack=%0d done=%0d want 1/10", o_ack_cyc, o_done_cyc); end
    checks++; if (i_line !== m_i_line || d_line !== m_d_line || proto_err !== 1'b0) begin
      errors++; $display("FAIL midreset_line got %h want %h", i_line, m_i_line); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ack_delay();
    test_gaps();
    test_random();
    test_bad_tag();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
